exec_control: RTL



---
 rtl/mips_pkg.sv | 24 ++
 rtl/exec_control_sat_counter.sv | 32 +++
 rtl/exec_control.sv | 106 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode, host-command and sequencer-state definitions shared by
// exec_control and the debug unit.
package mips_pkg;

    localparam int SIZEOP = 6;

    localparam logic [SIZEOP-1:0] OP_HALT = 6'b111111;
    localparam logic [SIZEOP-1:0] OP_NOP  = 6'b111000;

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DRAIN,
        ST_HALTED,
        ST_CLEAR
    } exec_state_e;

endpackage

// File: rtl/exec_control_sat_counter.sv
// sat_counter: enabled up-counter that sticks at all-ones; clear has priority
// over enable.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i && count_q != {W{1'b1}})
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/exec_control.sv
// exec_control: run/step sequencer for the MIPS pipeline. Gates pipeline and
// PC enables from host commands, drains the pipeline after HALT in decode.
module exec_control
    import mips_pkg::*;
#(
    parameter int SIZEOP       = 6,
    parameter int CYCLE_W      = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic               i_id_valid,
    input  logic [SIZEOP-1:0]  i_id_opcode,
    output logic               o_pipe_en,
    output logic               o_pc_en,
    output logic               o_if_kill,
    output logic               o_flush,
    output logic               o_halted,
    output logic               o_done,
    output logic [CYCLE_W-1:0] o_cycle_count
);

    localparam int DW = ($clog2(DRAIN_CYCLES) > 0) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [SIZEOP-1:0] HALT_OP = SIZEOP'(OP_HALT);

    exec_state_e   state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          done_q, done_d;
    logic          accept, halt_seen;

    assign o_cmd_ready = state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_HALTED;
    assign o_pipe_en   = state_q == ST_RUN || state_q == ST_STEP || state_q == ST_DRAIN;
    assign o_pc_en     = state_q == ST_RUN || state_q == ST_STEP;
    assign o_if_kill   = state_q == ST_DRAIN;
    assign o_flush     = state_q == ST_CLEAR;
    assign o_halted    = state_q == ST_HALTED;
    assign o_done      = done_q;

    assign accept    = i_cmd_valid && o_cmd_ready;
    assign halt_seen = i_id_valid && i_id_opcode == HALT_OP;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE:
                if (accept)
                    state_d = i_cmd == CMD_RUN   ? ST_RUN   :
                              i_cmd == CMD_STEP  ? ST_STEP  :
                              i_cmd == CMD_CLEAR ? ST_CLEAR : ST_IDLE;
            ST_RUN:
                if (accept && i_cmd == CMD_ABORT) begin
                    state_d = ST_IDLE;
                end else if (halt_seen) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                end
            ST_STEP:
                if (halt_seen) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            ST_DRAIN:
                if (drain_q == '0) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            ST_HALTED:
                if (accept && i_cmd == CMD_CLEAR)
                    state_d = ST_CLEAR;
            ST_CLEAR:
                state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    sat_counter #(.W(CYCLE_W)) u_cycles (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .en_i    (o_pipe_en),
        .clr_i   (o_flush),
        .count_o (o_cycle_count)
    );

endmodule
